sim_run_controller: RTL

Parametrised run controller for the single-cycle RISC-V core. It sequences the core's reset, counts cycles and retired instructions, and ends a run on a tohost store, a timeout, or an optional self-loop halt. It then reports a sticky pass/fail/timeout status. It sits between the top-level bench (clock and reset source) and the processor, and it is synthesisable, so the same controller serves simulation and FPGA bring-up.

---
 rtl/sim_run_controller_pkg.sv | 10 +
 rtl/sim_run_controller_if.sv | 37 +++
 rtl/sim_run_controller_sat_counter.sv | 17 +
 rtl/sim_run_controller.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sim_run_controller_pkg.sv
// sim_ctrl_pkg: shared types and constants for the simulation run controller.
//   run_state_e     : controller FSM states (HOLD / RUN / DONE)
//   PASS_VAL        : tohost value that signals a passing run
//   TOHOST_ADDR_DEF : default data-memory address of the tohost word
package sim_ctrl_pkg;
  typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, DONE = 2'd2} run_state_e;

  localparam int unsigned PASS_VAL        = 1;
  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
endpackage

// File: rtl/sim_run_controller_if.sv
// sim_run_controller_if: core-side monitor inputs and run status outputs.
//   retire_valid/retire_pc        : retire stream from the core
//   dmem_we/dmem_addr/dmem_wdata  : data-memory write port of the core
//   core_reset, running, done, pass, fail, timeout, fail_code,
//   cycle_count, instret_count    : controller outputs
// Modports: slave = controller side, master = core/bench side.
interface sim_run_controller_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             retire_valid;
  logic [XLEN-1:0]  retire_pc;
  logic             dmem_we;
  logic [XLEN-1:0]  dmem_addr;
  logic [XLEN-1:0]  dmem_wdata;
  logic             core_reset;
  logic             running;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [XLEN-1:0]  fail_code;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;

  modport slave (
    input  retire_valid, retire_pc, dmem_we, dmem_addr, dmem_wdata,
    output core_reset, running, done, pass, fail, timeout, fail_code,
           cycle_count, instret_count
  );

  modport master (
    output retire_valid, retire_pc, dmem_we, dmem_addr, dmem_wdata,
    input  core_reset, running, done, pass, fail, timeout, fail_code,
           cycle_count, instret_count
  );
endinterface

// File: rtl/sim_run_controller_sat_counter.sv
// sat_counter: W-bit up counter, synchronous active-high reset to 0,
// counts while en is high and sticks at all-ones.
//   clk, reset, en : inputs
//   q              : count value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)                q <= '0;
    else if (en && (q != '1)) q <= q + 1'b1;
  end
endmodule

// File: rtl/sim_run_controller.sv
// sim_run_controller: sequences the core reset, counts RUN cycles and
// retired instructions, and ends the run on a tohost store, a timeout or
// (with SELF_LOOP_HALT_EN defined) a self-loop halt. Status is sticky
// until reset.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : sim_run_controller_if.slave (monitor inputs, status outputs)
// Optional feature macro: SELF_LOOP_HALT_EN.
module sim_run_controller
  import sim_ctrl_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              CNT_W        = 32,
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 20,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(TOHOST_ADDR_DEF),
  parameter int              LOOP_THRESH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  sim_run_controller_if.slave bus
);
  localparam int HW = $clog2(RESET_CYCLES + 1);

  run_state_e       state_q, state_d;
  logic [HW-1:0]    hold_q;
  logic [CNT_W-1:0] cyc_q, ins_q;
  logic             pass_q, fail_q, to_q;
  logic [XLEN-1:0]  code_q;

  logic in_run, tohost, pass_ev, fail_ev, halt_ev, to_ev, end_ev;

  assign in_run  = (state_q == RUN);
  assign tohost  = in_run && bus.dmem_we && (bus.dmem_addr == TOHOST_ADDR);
  assign pass_ev = tohost && (bus.dmem_wdata == XLEN'(PASS_VAL));
  assign fail_ev = tohost && bus.dmem_wdata[0] && (bus.dmem_wdata != XLEN'(PASS_VAL));
  // Count is pre-increment, so M-1 here means this is the M-th RUN cycle.
  assign to_ev   = in_run && (cyc_q == CNT_W'(MAX_CYCLES - 1));
  assign end_ev  = pass_ev || fail_ev || halt_ev || to_ev;

`ifdef SELF_LOOP_HALT_EN
  localparam int LW = $clog2(LOOP_THRESH + 1);

  logic [XLEN-1:0] last_pc_q;
  logic            last_vld_q;
  logic [LW-1:0]   streak_q, streak_d;

  // Streak is the length of the current run of identical retire PCs;
  // the run ends in DONE before it could exceed LOOP_THRESH.
  always_comb begin
    streak_d = LW'(1);
    if (last_vld_q && (bus.retire_pc == last_pc_q)) streak_d = streak_q + 1'b1;
  end

  assign halt_ev = in_run && bus.retire_valid && (streak_d >= LW'(LOOP_THRESH));

  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
      streak_q   <= '0;
    end else if (in_run && bus.retire_valid) begin
      last_pc_q  <= bus.retire_pc;
      last_vld_q <= 1'b1;
      streak_q   <= streak_d;
    end
  end
`else
  logic unused_loop;
  assign unused_loop = ^{bus.retire_pc, (LOOP_THRESH != 0)};
  assign halt_ev     = 1'b0;
`endif

  // FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= HOLD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (hold_q == '0) state_d = RUN;
      RUN:     if (end_ev)       state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                                hold_q <= HW'(RESET_CYCLES);
    else if (state_q == HOLD && hold_q != '0) hold_q <= hold_q - 1'b1;
  end

  // Sticky status; the priority chain guarantees a single status bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      to_q   <= 1'b0;
      code_q <= '0;
    end else if (in_run) begin
      if (pass_ev) pass_q <= 1'b1;
      else if (fail_ev) begin
        fail_q <= 1'b1;
        code_q <= bus.dmem_wdata >> 1;
      end
      else if (halt_ev) pass_q <= 1'b1;
      else if (to_ev)   to_q   <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk(clk), .reset(reset), .en(in_run), .q(cyc_q)
  );

  sat_counter #(.W(CNT_W)) u_ins (
    .clk(clk), .reset(reset), .en(in_run && bus.retire_valid), .q(ins_q)
  );

  assign bus.core_reset    = (state_q != RUN);
  assign bus.running       = in_run;
  assign bus.done          = (state_q == DONE);
  assign bus.pass          = pass_q;
  assign bus.fail          = fail_q;
  assign bus.timeout       = to_q;
  assign bus.fail_code     = code_q;
  assign bus.cycle_count   = cyc_q;
  assign bus.instret_count = ins_q;
endmodule
